// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: one outstanding fetch, line refill over an
// INCR burst, sticky refill error reported as SLVERR and never cached.
module icache_direct #(
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fence_i,
   input  logic [31:0] ifu_araddr,
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_rresp,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   output logic [31:0] icache_araddr,
   output logic        icache_arvalid,
   input  logic        icache_arready,
   output logic [7:0]  icache_arlen,
   output logic [1:0]  icache_arburst,
   input  logic [31:0] icache_rdata,
   input  logic [1:0]  icache_rresp,
   input  logic        icache_rvalid,
   output logic        icache_rready,
   input  logic        icache_rlast
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam int CNT_W = OFF_W + 1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // the source holds payload stable while valid=1 and ready=0.
   typedef enum logic [2:0] {IDLE, CHECK, MISS_AR, MISS_R, RESP} state_t;

   state_t state, state_next;

   logic [31:0]      addr_q;
   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_mem  [SETS];
   logic [31:0]      data_mem [SETS*LINE_WORDS];
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             fenced_q;
   logic [31:0]      resp_data_q;
   logic [1:0]       resp_resp_q;

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_off;
   logic             hit;
   logic             beat;
   logic             beat_err;
   logic             err_next;
   logic             unused_low_bits;

   assign req_tag = addr_q[31 -: TAG_W];
   assign req_idx = addr_q[2+OFF_W +: IDX_W];
   assign req_off = addr_q[2 +: OFF_W];
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign beat    = (state == MISS_R) && icache_rvalid;

   // Counter MSB set means LINE_WORDS beats already arrived: any further beat is an overrun.
   assign beat_err = (icache_rresp != 2'b00) || cnt_q[OFF_W] ||
                     (icache_rlast && (cnt_q != CNT_W'(LINE_WORDS - 1)));
   assign err_next = err_q | beat_err;

   assign unused_low_bits = ^{addr_q[1:0], ifu_araddr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next     = state;
      ifu_arready    = 1'b0;
      ifu_rvalid     = 1'b0;
      ifu_rdata      = 32'h0;
      ifu_rresp      = 2'b00;
      icache_arvalid = 1'b0;
      icache_araddr  = 32'h0;
      icache_arlen   = 8'h0;
      icache_arburst = 2'b00;
      icache_rready  = 1'b0;
      case (state)
         IDLE: begin
            ifu_arready = 1'b1;
            if (ifu_arvalid) state_next = CHECK;
         end
         CHECK: state_next = hit ? RESP : MISS_AR;
         MISS_AR: begin
            icache_arvalid = 1'b1;
            icache_araddr  = {addr_q[31:2+OFF_W], {(OFF_W+2){1'b0}}};
            icache_arlen   = 8'(LINE_WORDS - 1);
            icache_arburst = 2'b01;
            if (icache_arready) state_next = MISS_R;
         end
         MISS_R: begin
            icache_rready = 1'b1;
            if (icache_rvalid && icache_rlast) state_next = RESP;
         end
         RESP: begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = resp_data_q;
            ifu_rresp  = resp_resp_q;
            if (ifu_rready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (rst) begin
         state_next     = IDLE;
         ifu_arready    = 1'b0;
         ifu_rvalid     = 1'b0;
         ifu_rdata      = 32'h0;
         ifu_rresp      = 2'b00;
         icache_arvalid = 1'b0;
         icache_araddr  = 32'h0;
         icache_arlen   = 8'h0;
         icache_arburst = 2'b00;
         icache_rready  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= 32'h0;
         valid_q     <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         fenced_q    <= 1'b0;
         resp_data_q <= 32'h0;
         resp_resp_q <= 2'b00;
      end else begin
         if (state == IDLE && ifu_arvalid) addr_q <= ifu_araddr;
         if (state == CHECK) begin
            fenced_q <= 1'b0;
            if (hit) begin
               resp_data_q <= data_mem[{req_idx, req_off}];
               resp_resp_q <= 2'b00;
            end
         end
         if (state == MISS_AR && icache_arready) begin
            cnt_q <= '0;
            err_q <= 1'b0;
         end
         // A fence seen anywhere in the refill means the returning line may be stale.
         if (fence_i && (state == MISS_AR || state == MISS_R)) fenced_q <= 1'b1;
         if (beat) begin
            if (!cnt_q[OFF_W]) cnt_q <= cnt_q + CNT_W'(1);
            err_q <= err_next;
            if (cnt_q == {1'b0, req_off}) resp_data_q <= icache_rdata;
            if (icache_rlast) begin
               resp_resp_q      <= err_next ? 2'b10 : 2'b00;
               valid_q[req_idx] <= !err_next && !fenced_q && !fence_i;
            end
         end
         if (fence_i) valid_q <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && beat && !cnt_q[OFF_W]) data_mem[{req_idx, cnt_q[OFF_W-1:0]}] <= icache_rdata;
      if (!rst && beat && icache_rlast) tag_mem[req_idx] <= req_tag;
   end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus randomized fetches checked
// against a line-level cache model and an address-derived memory image.
module tb_icache_direct;

   localparam int LW   = 4;
   localparam int SETS = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fence_i = 1'b0;
   logic [31:0] ifu_araddr = 32'h0;
   logic        ifu_arvalid = 1'b0;
   logic        ifu_arready;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rvalid;
   logic        ifu_rready = 1'b0;
   logic [31:0] icache_araddr;
   logic        icache_arvalid;
   logic        icache_arready = 1'b0;
   logic [7:0]  icache_arlen;
   logic [1:0]  icache_arburst;
   logic [31:0] icache_rdata = 32'h0;
   logic [1:0]  icache_rresp = 2'b00;
   logic        icache_rvalid = 1'b0;
   logic        icache_rready;
   logic        icache_rlast = 1'b0;

   icache_direct #(.LINE_WORDS(LW), .SETS(SETS)) dut (
      .clk(clk), .rst(rst), .fence_i(fence_i),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
      .ifu_rready(ifu_rready),
      .icache_araddr(icache_araddr), .icache_arvalid(icache_arvalid),
      .icache_arready(icache_arready), .icache_arlen(icache_arlen),
      .icache_arburst(icache_arburst), .icache_rdata(icache_rdata),
      .icache_rresp(icache_rresp), .icache_rvalid(icache_rvalid),
      .icache_rready(icache_rready), .icache_rlast(icache_rlast)
   );

   // Clock/reset block
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard and reference model state
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   bit          mv [SETS];
   logic [31:0] mt [SETS];
   logic [31:0] last_resp = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & ~32'h3;
      return (w * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
   endfunction

   function automatic int line_idx(input logic [31:0] a);
      return int'((a / (4 * LW)) % SETS);
   endfunction

   function automatic logic [31:0] line_tag(input logic [31:0] a);
      return a / (4 * LW * SETS);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_flush();
      for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
   endtask

   task automatic pulse_fence();
      @(negedge clk);
      fence_i = 1'b1;
      @(negedge clk);
      fence_i = 1'b0;
      model_flush();
   endtask

   // Driver: one complete fetch, acting as both IFU and memory arbiter.
   task automatic fetch(input logic [31:0] addr, input int err_beat, input int fence_beat,
                        input int nbeats, input int ar_delay, input int rr_delay);
      int          idx, off;
      logic [31:0] tag, base, exp_data;
      logic [1:0]  exp_resp;
      bit          exp_hit, exp_err;
      idx  = line_idx(addr);
      off  = int'((addr / 4) % LW);
      tag  = line_tag(addr);
      base = addr - (addr % (4 * LW));
      exp_hit = mv[idx] && (mt[idx] == tag);
      @(negedge clk);
      check("arready_idle", 32'(ifu_arready), 32'd1);
      ifu_araddr  = addr;
      ifu_arvalid = 1'b1;
      @(negedge clk);
      ifu_arvalid = 1'b0;
      ifu_araddr  = $urandom;
      check("check_no_rvalid", 32'(ifu_rvalid), 32'd0);
      check("check_no_arready", 32'(ifu_arready), 32'd0);
      @(negedge clk);
      if (exp_hit) begin
         exp_data = mem_word(addr);
         exp_resp = 2'b00;
         check("hit_no_refill", 32'(icache_arvalid), 32'd0);
      end else begin
         check("refill_arvalid", 32'(icache_arvalid), 32'd1);
         check("refill_araddr", icache_araddr, base);
         check("refill_arlen", 32'(icache_arlen), 32'(LW - 1));
         check("refill_arburst", 32'(icache_arburst), 32'd1);
         for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk);
            check("araddr_stable", icache_araddr, base);
            check("arlen_stable", 32'(icache_arlen), 32'(LW - 1));
            check("arvalid_held", 32'(icache_arvalid), 32'd1);
         end
         icache_arready = 1'b1;
         @(negedge clk);
         icache_arready = 1'b0;
         check("ar_dropped", 32'(icache_arvalid), 32'd0);
         check("araddr_zero", icache_araddr, 32'h0);
         exp_err  = (nbeats != LW);
         exp_data = last_resp;
         for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            check("rready_in_burst", 32'(icache_rready), 32'd1);
            check("no_rvalid_in_burst", 32'(ifu_rvalid), 32'd0);
            icache_rvalid = 1'b1;
            icache_rdata  = mem_word(base + 32'(4 * b));
            icache_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            icache_rlast  = (b == nbeats - 1);
            fence_i       = (b == fence_beat);
            if (b == err_beat) exp_err = 1'b1;
            if (b == off) exp_data = mem_word(base + 32'(4 * b));
            if (b == fence_beat) model_flush();
            @(negedge clk);
            icache_rvalid = 1'b0;
            icache_rlast  = 1'b0;
            icache_rresp  = 2'b00;
            fence_i       = 1'b0;
         end
         mt[idx]  = tag;
         mv[idx]  = !exp_err && !(fence_beat >= 0 && fence_beat < nbeats);
         exp_resp = exp_err ? 2'b10 : 2'b00;
      end
      exp_q.push_back(exp_data);
      last_resp = exp_data;
      check("rvalid_latency", 32'(ifu_rvalid), 32'd1);
      for (int i = 0; i < rr_delay; i++) begin
         @(negedge clk);
         check("resp_held_rvalid", 32'(ifu_rvalid), 32'd1);
         check("resp_held_rdata", ifu_rdata, exp_q[0]);
         check("resp_no_arready", 32'(ifu_arready), 32'd0);
      end
      ifu_rready = 1'b1;
      check("rdata", ifu_rdata, exp_q.pop_front());
      check("rresp", 32'(ifu_rresp), 32'(exp_resp));
      @(negedge clk);
      ifu_rready = 1'b0;
      check("resp_done", 32'(ifu_rvalid), 32'd0);
   endtask

   // Refill cut short by reset; leftover beats must be ignored afterwards.
   task automatic aborted_refill(input logic [31:0] addr);
      logic [31:0] base;
      base = addr - (addr % (4 * LW));
      @(negedge clk);
      ifu_araddr  = addr;
      ifu_arvalid = 1'b1;
      @(negedge clk);
      ifu_arvalid = 1'b0;
      @(negedge clk);
      check("abort_arvalid", 32'(icache_arvalid), 32'd1);
      icache_arready = 1'b1;
      @(negedge clk);
      icache_arready = 1'b0;
      for (int b = 0; b < LW; b++) begin
         icache_rvalid = 1'b1;
         icache_rdata  = mem_word(base + 32'(4 * b));
         icache_rlast  = (b == LW - 1);
         if (b == 2) rst = 1'b1;
         @(negedge clk);
         if (b == 2) begin
            check("rst_arready", 32'(ifu_arready), 32'd0);
            check("rst_rready", 32'(icache_rready), 32'd0);
            check("rst_rvalid", 32'(ifu_rvalid), 32'd0);
            rst = 1'b0;
         end else if (b == 3) begin
            check("post_rst_rready", 32'(icache_rready), 32'd0);
            check("post_rst_arready", 32'(ifu_arready), 32'd1);
         end
      end
      icache_rvalid = 1'b0;
      icache_rlast  = 1'b0;
      @(negedge clk);
      check("post_rst_no_resp", 32'(ifu_rvalid), 32'd0);
      model_flush();
      last_resp = 32'h0;
   endtask

   initial begin
      logic [31:0] a;
      int eb, fb, nb;
      model_flush();
      ifu_arvalid = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ifu_arready", 32'(ifu_arready), 32'd0);
      check("rst_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
      check("rst_ifu_rdata", ifu_rdata, 32'h0);
      check("rst_ifu_rresp", 32'(ifu_rresp), 32'd0);
      check("rst_icache_arvalid", 32'(icache_arvalid), 32'd0);
      check("rst_icache_araddr", icache_araddr, 32'h0);
      check("rst_icache_arlen", 32'(icache_arlen), 32'd0);
      check("rst_icache_arburst", 32'(icache_arburst), 32'd0);
      check("rst_icache_rready", 32'(icache_rready), 32'd0);
      ifu_arvalid = 1'b0;
      rst = 1'b0;

      fetch(32'h8000_0008, -1, -1, LW, 0, 0);   // cold miss, word 2
      fetch(32'h8000_000C, -1, -1, LW, 0, 0);   // hit after fill
      fetch(32'h8000_0100, -1, -1, LW, 0, 0);   // conflict evicts
      fetch(32'h8000_0000, -1, -1, LW, 0, 0);   // misses again
      fetch(32'h8000_0204, 1, -1, LW, 0, 0);    // error beat
      fetch(32'h8000_0204, -1, -1, LW, 0, 0);   // not cached -> miss
      fetch(32'h8000_0310, -1, 2, LW, 0, 0);    // fence mid-burst
      fetch(32'h8000_0310, -1, -1, LW, 0, 0);
      fetch(32'h8000_0410, -1, LW - 1, LW, 0, 0); // fence on rlast
      fetch(32'h8000_0410, -1, -1, LW, 0, 0);
      fetch(32'h8000_0520, -1, -1, LW, 3, 5);   // backpressure both sides
      fetch(32'h8000_0528, -1, -1, LW, 0, 5);
      fetch(32'h8000_0600, -1, -1, LW - 2, 0, 0); // short burst
      fetch(32'h8000_0604, -1, -1, LW, 0, 0);
      fetch(32'h8000_0700, -1, -1, LW + 1, 0, 0); // overlong burst
      fetch(32'h8000_0604, -1, -1, LW, 0, 0);
      pulse_fence();
      fetch(32'h8000_0604, -1, -1, LW, 0, 0);
      pulse_fence();
      aborted_refill(32'h9000_0040);
      fetch(32'h9000_0040, -1, -1, LW, 1, 1);
      fetch(32'h9000_0044, -1, -1, LW, 0, 0);

      for (int n = 0; n < 80; n++) begin
         a  = 32'h8000_0000 + 32'($urandom_range(0, 2) * 256) + 32'($urandom_range(0, 3) * 16)
              + 32'($urandom_range(0, LW - 1) * 4) + 32'($urandom_range(0, 3));
         eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
         fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
         nb = ($urandom_range(0, 11) == 0) ? int'($urandom_range(LW - 1, LW + 1)) : LW;
         fetch(a, eb, fb, nb, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         if ($urandom_range(0, 15) == 0) pulse_fence();
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
